// File: rtl/char_pwm_decoder_pkg.sv
// Shared PWM character encoding used by both char_pwm_gen and char_pwm_decoder.
// The character widths are defined once here so the two ends cannot drift apart.
package char_pwm_pkg;

  localparam int unsigned PERIOD_DEF = 20;

  typedef logic [1:0] pwm_char_t;

  typedef logic [1:0] dec_state_t;
  localparam dec_state_t ST_IDLE = 2'd0;
  localparam dec_state_t ST_HIGH = 2'd1;
  localparam dec_state_t ST_LOW  = 2'd2;

  // High time in cycles for character k within a frame of 'period' cycles.
  function automatic int unsigned char_width(input int unsigned k, input int unsigned period);
    return (k + 1) * period / 5;
  endfunction

endpackage

// File: rtl/char_pwm_decoder_if.sv
// PWM line in, decoded character stream out.
// The bridge-side driver uses master; the decoder uses slave.
interface char_pwm_decoder_if;
  import char_pwm_pkg::*;

  logic      digit;
  pwm_char_t char_out;
  logic      char_valid;
  logic      locked;
  logic      frame_err;

  modport master (output digit, input char_out, char_valid, locked, frame_err);
  modport slave  (input digit, output char_out, char_valid, locked, frame_err);
endinterface

// File: rtl/char_pwm_decoder_edge_sync.sv
// Two-flop synchronizer for the asynchronous PWM line.
// Also provides registered-history rise/fall pulses on the synchronized level.
module pwm_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= din_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/char_pwm_decoder.sv
// Measures high width and period of each PWM frame, classifies it into a 2-bit
// character and reports it once CONFIRM consecutive identical frames are seen.
//   state   | meaning
//   ST_IDLE | no frame in progress, waiting for a rising edge
//   ST_HIGH | inside the high part of a frame, counting width
//   ST_LOW  | inside the low part, counting period until the closing rise
module char_pwm_decoder
  import char_pwm_pkg::*;
#(
  parameter int unsigned PERIOD  = PERIOD_DEF,
  parameter int unsigned TOL     = 1,
  parameter int unsigned CONFIRM = 2
) (
  input logic              clk,
  input logic              rst_n,
  char_pwm_decoder_if.slave bus
);

  localparam int unsigned CW = $clog2(2 * PERIOD + 2);
  localparam int unsigned MW = $clog2(CONFIRM + 1);

  logic          rise, fall;
  dec_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] width_q, width_d;
  pwm_char_t     cand_q, cand_d;
  logic [MW-1:0] match_q, match_d;
  pwm_char_t     char_q, char_d;
  logic          valid_q, valid_d;
  logic          locked_q, locked_d;
  logic          err_q, err_d;
  logic [2:0]    verdict;
  logic          period_ok;
  logic          frame_ok;
  pwm_char_t     frame_cls;

  pwm_edge_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .din_i  (bus.digit),
    .rise_o (rise),
    .fall_o (fall)
  );

  // {exactly-one-window-hit, class}; windows never overlap while TOL < PERIOD/10
  function automatic logic [2:0] classify(input logic [CW-1:0] w);
    int unsigned wv;
    int unsigned wk;
    int unsigned hits;
    pwm_char_t   cls;
    wv   = 32'(w);
    hits = 0;
    cls  = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      wk = char_width(k, PERIOD);
      if (wv + TOL >= wk && wv <= wk + TOL) begin
        hits = hits + 1;
        cls  = k[1:0];
      end
    end
    return {hits == 1, cls};
  endfunction

  assign verdict   = classify(width_q);
  assign period_ok = (32'(cnt_q) + TOL >= PERIOD) && (32'(cnt_q) <= PERIOD + TOL);
  assign frame_ok  = verdict[2] & period_ok;
  assign frame_cls = verdict[1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    width_d  = width_q;
    cand_d   = cand_q;
    match_d  = match_q;
    char_d   = char_q;
    locked_d = locked_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          cnt_d   = CW'(1);
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        cnt_d = cnt_q + 1'b1;
        if (fall) begin
          width_d = cnt_q;
          state_d = ST_LOW;
        end else if (32'(cnt_q) > PERIOD) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_LOW: begin
        cnt_d = cnt_q + 1'b1;
        if (rise) begin
          cnt_d   = CW'(1);
          state_d = ST_HIGH;
          if (!frame_ok) begin
            err_d = 1'b1;
          end else begin
            if (match_q != '0 && frame_cls == cand_q) begin
              if (32'(match_q) < CONFIRM) match_d = match_q + 1'b1;
            end else begin
              cand_d  = frame_cls;
              match_d = MW'(1);
            end
            if (32'(match_d) >= CONFIRM) begin
              char_d   = frame_cls;
              locked_d = 1'b1;
              valid_d  = 1'b1;
            end else begin
              locked_d = 1'b0;
            end
          end
        end else if (32'(cnt_q) > PERIOD + TOL) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
    // Any malformed or timed-out frame breaks the confirmation run.
    if (err_d) begin
      match_d  = '0;
      locked_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      width_q  <= '0;
      cand_q   <= '0;
      match_q  <= '0;
      char_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      width_q  <= width_d;
      cand_q   <= cand_d;
      match_q  <= match_d;
      char_q   <= char_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign bus.char_out   = char_q;
  assign bus.char_valid = valid_q;
  assign bus.locked     = locked_q;
  assign bus.frame_err  = err_q;

endmodule

// File: tb/tb_char_pwm_decoder.sv
// Bench for char_pwm_decoder: timestamp-based frame model compared every cycle,
// plus directed scenarios with hand-computed outcomes and a randomized stream.
module tb_char_pwm_decoder;

  localparam int PERIOD  = 20;
  localparam int TOL     = 1;
  localparam int CONFIRM = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   vcnt   = 0;
  int   ecnt   = 0;

  char_pwm_decoder_if bus ();

  char_pwm_decoder #(.PERIOD(PERIOD), .TOL(TOL), .CONFIRM(CONFIRM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: frames described by the sample indices of their rise and fall.
  int         m_t = 0, m_rise = 0, m_fall = 0, m_run_cls = 0, m_run_len = 0;
  bit         m_prev = 0, m_busy = 0, m_fell = 0, m_lock = 0;
  logic [1:0] m_char = '0;
  logic [4:0] pipe0 = '0, pipe1 = '0, exp_cur = '0;  // {char, locked, valid, err}

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_rise = 0; m_fall = 0; m_run_cls = 0; m_run_len = 0;
    m_prev = 0; m_busy = 0; m_fell = 0; m_lock = 0; m_char = '0;
    pipe0 = '0; pipe1 = '0; exp_cur = '0;
  endtask

  task automatic model_step(input logic d);
    bit v, e;
    int hits, cls, wid, per;
    v = 0; e = 0; hits = 0; cls = 0;
    if (!m_busy) begin
      if (d && !m_prev) begin m_busy = 1; m_fell = 0; m_rise = m_t; end
    end else if (!m_fell) begin
      if (!d && m_prev) begin m_fell = 1; m_fall = m_t; end
      else if (m_t - m_rise > PERIOD) begin e = 1; m_busy = 0; end
    end else if (d && !m_prev) begin
      wid = m_fall - m_rise;
      per = m_t - m_rise;
      for (int k = 0; k < 4; k++)
        if (wid >= (k + 1) * PERIOD / 5 - TOL && wid <= (k + 1) * PERIOD / 5 + TOL) begin
          hits++;
          cls = k;
        end
      if (hits != 1 || per < PERIOD - TOL || per > PERIOD + TOL) e = 1;
      else begin
        if (m_run_len > 0 && cls == m_run_cls) begin
          if (m_run_len < CONFIRM) m_run_len++;
        end else begin
          m_run_cls = cls;
          m_run_len = 1;
        end
        if (m_run_len >= CONFIRM) begin m_char = cls[1:0]; m_lock = 1; v = 1; end
        else m_lock = 0;
      end
      m_rise = m_t;
      m_fell = 0;
    end else if (m_t - m_rise > PERIOD + TOL) begin
      e = 1; m_busy = 0;
    end
    if (e) begin m_run_len = 0; m_lock = 0; end
    m_prev = d;
    m_t++;
    // Synchronizer plus edge detector put DUT outputs two samples behind the line.
    exp_cur = pipe1;
    pipe1   = pipe0;
    pipe0   = {m_char, m_lock, v, e};
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (rst_n !== 1'b1) model_reset();
      else model_step(bus.digit);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        check("char_out", int'(bus.char_out), int'(exp_cur[4:3]));
        check("locked", int'(bus.locked), int'(exp_cur[2]));
        check("char_valid", int'(bus.char_valid), int'(exp_cur[1]));
        check("frame_err", int'(bus.frame_err), int'(exp_cur[0]));
        if (bus.char_valid === 1'b1) vcnt++;
        if (bus.frame_err === 1'b1) ecnt++;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog actual=running expected=finished at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic v, input int n);
    repeat (n) begin
      @(negedge clk);
      bus.digit = v;
    end
  endtask

  task automatic frame(input int w, input int p);
    drive(1'b1, w);
    drive(1'b0, p - w);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_char_out"}, int'(bus.char_out), 0);
    check({tag, "_locked"}, int'(bus.locked), 0);
    check({tag, "_char_valid"}, int'(bus.char_valid), 0);
    check({tag, "_frame_err"}, int'(bus.frame_err), 0);
  endtask

  initial begin
    int v0, e0, cls, w, p, r;
    rst_n     = 1'b0;
    bus.digit = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 5);

    // Ideal char 2: frames 2..4 are confirmed (5th rise closes frame 4).
    v0 = vcnt;
    repeat (5) frame(12, 20);
    #1;
    check("c2_pulses", vcnt - v0, 3);
    check("c2_char_out", int'(bus.char_out), 2);
    check("c2_locked", int'(bus.locked), 1);

    // Tolerance edges on char 1, then an out-of-window width.
    v0 = vcnt; e0 = ecnt;
    frame(7, 21); frame(9, 21); frame(10, 20); frame(8, 20);
    #1;
    check("tol_pulses", vcnt - v0, 2);
    check("tol_errs", ecnt - e0, 1);
    check("tol_char_out", int'(bus.char_out), 1);
    check("tol_locked", int'(bus.locked), 0);

    // Class change 0 -> 3.
    repeat (3) frame(4, 20);
    frame(16, 20); frame(16, 20);
    #1;
    check("chg_char_out_hold", int'(bus.char_out), 0);
    check("chg_locked_drop", int'(bus.locked), 0);
    frame(16, 20);
    #1;
    check("chg_char_out_new", int'(bus.char_out), 3);
    check("chg_locked", int'(bus.locked), 1);

    // Lock on char 1, then let the line go quiet.
    e0 = ecnt;
    repeat (3) frame(8, 20);
    #1;
    check("to_pre_char", int'(bus.char_out), 1);
    drive(1'b0, 30);
    #1;
    check("to_errs", ecnt - e0, 1);
    check("to_locked", int'(bus.locked), 0);
    check("to_char_out", int'(bus.char_out), 1);
    drive(1'b0, 30);
    #1;
    check("to_no_repeat", ecnt - e0, 1);

    // Stuck high, then relock.
    e0 = ecnt;
    drive(1'b1, 25);
    drive(1'b0, 5);
    #1;
    check("stuck_errs", ecnt - e0, 1);
    check("stuck_locked", int'(bus.locked), 0);
    v0 = vcnt;
    repeat (3) frame(12, 20);
    #1;
    check("relock_pulses", vcnt - v0, 1);
    check("relock_char", int'(bus.char_out), 2);
    check("relock_locked", int'(bus.locked), 1);

    // Reset in the middle of a high phase.
    drive(1'b1, 5);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    bus.digit = 1'b0;
    drive(1'b0, 3);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 4);
    v0 = vcnt;
    frame(12, 20); frame(12, 20);
    #1;
    check("midrst_first", vcnt - v0, 0);
    frame(12, 20);
    #1;
    check("midrst_second", vcnt - v0, 1);

    // Randomized stream with runs, jitter, malformed frames, gaps and stuck-high spells.
    cls = 0;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(9) < 3) cls = int'($urandom_range(3));
      w = (cls + 1) * PERIOD / 5 + int'($urandom_range(2 * TOL)) - TOL;
      p = PERIOD + int'($urandom_range(2 * TOL)) - TOL;
      r = int'($urandom_range(99));
      if (r < 8) w = int'($urandom_range(PERIOD - 4, 1));
      else if (r < 14) p = int'($urandom_range(PERIOD + TOL + 3, PERIOD - TOL - 2));
      else if (r < 17) drive(1'b0, 30);
      else if (r < 19) begin drive(1'b1, 24); drive(1'b0, 3); end
      if (p <= w) p = w + 1;
      frame(w, p);
    end
    drive(1'b0, 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/char_pwm_decoder.md
Name: char_pwm_decoder

Overview:
Receive-side counterpart of char_pwm_gen. It samples the serial `digit` PWM line, measures the high width and the period of each frame, and classifies the frame into one of four 2-bit characters. It confirms the character over CONFIRM consecutive frames and reports it with a valid pulse. It sits at the bridge input, feeding decoded characters to the neuromorphic core interface.

Parameters:
- PERIOD, 20, frame length in clk cycles (rising edge to rising edge).
- TOL, 1, allowed ± deviation in cycles on width and period; must be < PERIOD/10.
- CONFIRM, 2, consecutive identical valid frames required before reporting (≥1).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- digit  input  1  PWM character line (asynchronous to clk)
- char_out  output  2  last confirmed character
- char_valid  output  1  one-cycle pulse per confirmed valid frame
- locked  output  1  high while CONFIRM-qualified frames keep arriving
- frame_err  output  1  one-cycle pulse on malformed or timed-out frame

Behaviour:
- Encoding (fixed):
  - Frame = PERIOD cycles, starting at a rising edge.
  - `digit` is high for W_k = (k+1)*PERIOD/5 cycles, then low for the rest.
  - PERIOD=20 gives W = 4, 8, 12, 16 for chars 0..3.
- Input path:
  - 2-flop synchronizer on `digit`, then a registered edge detector.
  - All widths are measured on the synchronized signal.
  - Fixed latency is 2 cycles.
- Reset (async, rst_n=0):
  - state=IDLE, counters=0, match count=0.
  - char_out=2'b00, char_valid=0, locked=0, frame_err=0.
  - Synchronizer flops reset to 0.
- Counter width is $clog2(2*PERIOD+2).
- FSM:
  - IDLE: wait for a synchronized rising edge. On the edge: cnt<=1, go to HIGH.
  - HIGH: cnt++ each cycle.
    - On falling edge: latch width=cnt, go to LOW.
    - If cnt > PERIOD (stuck high): frame_err, go to IDLE.
  - LOW: cnt++ each cycle.
    - On rising edge: evaluate the frame; cnt<=1; stay in the frame loop (go to HIGH).
    - If cnt > PERIOD+TOL with no edge: frame_err, go to IDLE.
- Frame evaluation, done on the rising edge that closes the frame:
  - Period must be in [PERIOD-TOL, PERIOD+TOL].
  - Width must fall in exactly one window [W_k-TOL, W_k+TOL].
  - On failure: frame_err pulses the next cycle; match count=0; locked=0; char_out holds.
  - If class == previous candidate: match count++ (saturating at CONFIRM). Otherwise: candidate=class, match count=1.
  - When match count ≥ CONFIRM after the update:
    - char_out<=class, locked<=1.
    - char_valid pulses the cycle after the closing synchronized rising edge.
    - Every further matching frame produces another pulse.
  - When match count < CONFIRM after the update, including a class change: locked<=0, no pulse.
- Simultaneous events:
  - A timeout and an edge in the same cycle: the edge wins.
  - A frame error clears the match count in the same update.
- Idle line (constant low or high): after the timeout, frame_err pulses once and locked=0. No repeated errors while the FSM stays in IDLE.
- Reset mid-frame discards all partial measurements immediately.

Decomposition:
- Shared package char_pwm_pkg holds:
  - The PERIOD default.
  - The W_k width function or localparams.
  - The 2-bit character typedef.
  - The decoder state enum (IDLE, HIGH, LOW).
- char_pwm_gen imports the same package so the encoding has one definition.
- One sub-module: pwm_edge_sync (2-flop synchronizer plus rise/fall pulse outputs).
- Width classification stays inline as a combinational function.

Test Plan:
- Char 2, ideal frames: drive width 12 / period 20 for 4 frames -> char_valid pulses at frames 2, 3, 4; char_out=2; locked=1 from frame 2.
- Tolerance edges: char 1 with widths 7, then 9, period 21 -> both accepted, char_out=1. Width 10 -> frame_err pulse, locked=0, char_out stays 1.
- Class change: 3 frames of char 0 (width 4), then char 3 (width 16) -> no pulse on the first char-3 frame; pulse with char_out=3 on the second.
- Timeout: after locking on char 1, hold digit low for 30 cycles -> a single frame_err about PERIOD+TOL+1 cycles after the last rise; locked=0; no further errors.
- Stuck high: digit high for 25 cycles -> frame_err when cnt exceeds 20; FSM to IDLE; a later valid stream relocks after CONFIRM frames.
- Reset mid-frame: assert rst_n=0 during HIGH of a char 2 frame -> all outputs 0 asynchronously. After release, the first complete frame gives no pulse; the second gives a pulse.
